// File: rtl/pulse_channel.sv
// Pulse-wave voice: note-loaded phase accumulator, four-step duty compare and a
// tick-driven linear decay envelope, producing a registered sample for the mixer.
module pulse_channel #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned OUT_WIDTH   = 9,
  parameter int unsigned DECAY_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick_stb,
  input  logic                   i_note_stb,
  input  logic [PHASE_WIDTH-1:0] i_phase_delta,
  input  logic [1:0]             i_duty,
  input  logic [OUT_WIDTH-1:0]   i_volume,
  input  logic [DECAY_WIDTH-1:0] i_decay_period,
  input  logic                   i_enable,
  output logic [OUT_WIDTH-1:0]   o_output,
  output logic                   o_frame_pulse,
  output logic                   o_active
);

  localparam logic [DECAY_WIDTH-1:0] DecayOne = DECAY_WIDTH'(1);
  localparam logic [OUT_WIDTH-1:0]   EnvOne   = OUT_WIDTH'(1);

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] delta_q, delta_d;
  logic [1:0]             duty_q, duty_d;
  logic [DECAY_WIDTH-1:0] period_q, period_d;
  logic [OUT_WIDTH-1:0]   envelope_q, envelope_d;
  logic [DECAY_WIDTH-1:0] decay_cnt_q, decay_cnt_d;
  logic [OUT_WIDTH-1:0]   output_q, output_d;
  logic                   frame_q, frame_d;
  logic                   active_q, active_d;

  logic [2:0] p;
  logic       high;
  logic       decay_en;

  always_comb begin
    phase_d     = phase_q;
    delta_d     = delta_q;
    duty_d      = duty_q;
    period_d    = period_q;
    envelope_d  = envelope_q;
    decay_cnt_d = decay_cnt_q;
    decay_en    = i_tick_stb && (period_q != '0) && (envelope_q != '0);

    if (i_note_stb) begin
      // A note load overrides any tick arriving in the same cycle.
      phase_d     = '0;
      delta_d     = i_phase_delta;
      duty_d      = i_duty;
      period_d    = i_decay_period;
      envelope_d  = i_volume;
      decay_cnt_d = '0;
    end else begin
      if (i_enable) begin
        phase_d = phase_q + delta_q;
      end
      if (decay_en) begin
        if (decay_cnt_q == period_q - DecayOne) begin
          decay_cnt_d = '0;
          envelope_d  = envelope_q - EnvOne;
        end else begin
          decay_cnt_d = decay_cnt_q + DecayOne;
        end
      end
    end
  end

  always_comb begin
    p    = phase_q[PHASE_WIDTH-1 -: 3];
    high = 1'b0;
    unique case (duty_q)
      2'd0: high = (p == 3'd0);
      2'd1: high = (p[2:1] == 2'd0);
      2'd2: high = ~p[2];
      2'd3: high = (p[2:1] != 2'd3);
    endcase
    output_d = (i_enable && high) ? envelope_q : '0;
    frame_d  = i_enable & phase_q[PHASE_WIDTH-1];
    active_d = (envelope_q != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q     <= '0;
      delta_q     <= '0;
      duty_q      <= '0;
      period_q    <= '0;
      envelope_q  <= '0;
      decay_cnt_q <= '0;
      output_q    <= '0;
      frame_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      delta_q     <= delta_d;
      duty_q      <= duty_d;
      period_q    <= period_d;
      envelope_q  <= envelope_d;
      decay_cnt_q <= decay_cnt_d;
      output_q    <= output_d;
      frame_q     <= frame_d;
      active_q    <= active_d;
    end
  end

  assign o_output      = output_q;
  assign o_frame_pulse = frame_q;
  assign o_active      = active_q;

endmodule

// File: tb/tb_pulse_channel.sv
// Bench for pulse_channel: directed scenarios plus random traffic, checked against
// a tick-count/threshold reference model of the voice.
module tb_pulse_channel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, note, en;
  logic [31:0] delta;
  logic [1:0]  duty;
  logic [8:0]  vol;
  logic [3:0]  per;
  logic [8:0]  o_output;
  logic        o_frame_pulse, o_active;

  always #5 clk = ~clk;

  pulse_channel dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_tick_stb    (tick),
    .i_note_stb    (note),
    .i_phase_delta (delta),
    .i_duty        (duty),
    .i_volume      (vol),
    .i_decay_period(per),
    .i_enable      (en),
    .o_output      (o_output),
    .o_frame_pulse (o_frame_pulse),
    .o_active      (o_active)
  );

  int checks = 0;
  int errors = 0;

  // Model: envelope is derived from ticks counted since the last note.
  logic [31:0] m_phase, m_delta;
  int          m_duty, m_period, m_vol, m_ticks;

  function automatic int m_env();
    if (m_period == 0) return m_vol;
    if (m_ticks / m_period >= m_vol) return 0;
    return m_vol - m_ticks / m_period;
  endfunction

  function automatic int m_cnt();
    if (m_period == 0) return 0;
    return m_ticks % m_period;
  endfunction

  // Fraction of the cycle spent high, as a phase threshold.
  function automatic logic [63:0] thresh(int d);
    case (d)
      0:       return 64'h2000_0000;
      1:       return 64'h4000_0000;
      2:       return 64'h8000_0000;
      default: return 64'hC000_0000;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = '0; m_delta = '0; m_duty = 0; m_period = 0; m_vol = 0; m_ticks = 0;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [63:0] eo;
    logic        efp, eact;
    int          e;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      eo = '0; efp = 1'b0; eact = 1'b0;
    end else begin
      e    = m_env();
      eo   = (en && ({32'b0, m_phase} < thresh(m_duty))) ? 64'(e) : 64'd0;
      efp  = en & m_phase[31];
      eact = (e != 0);
      if (note) begin
        m_phase = '0; m_delta = delta; m_duty = int'(duty);
        m_period = int'(per); m_vol = int'(vol); m_ticks = 0;
      end else begin
        if (en) m_phase = m_phase + m_delta;
        if (tick && m_period != 0 && e != 0) m_ticks++;
      end
    end
    #1;
    check("output", 64'(o_output), eo);
    check("frame_pulse", 64'(o_frame_pulse), 64'(efp));
    check("active", 64'(o_active), 64'(eact));
    check("phase", 64'(dut.phase_q), 64'(m_phase));
    check("decay_cnt", 64'(dut.decay_cnt_q), 64'(m_cnt()));
  endtask

  task automatic load(logic [31:0] d, logic [1:0] dt, logic [8:0] v, logic [3:0] p);
    delta = d; duty = dt; vol = v; per = p;
    note = 1'b1;
    step();
    note = 1'b0;
  endtask

  int hc;
  int exp_hc[4] = '{80, 160, 320, 480};
  int exp_env[9] = '{3, 3, 2, 2, 1, 1, 0, 0, 0};

  initial begin
    rst_n = 1'b0; tick = 1'b0; note = 1'b0; en = 1'b1;
    delta = '0; duty = '0; vol = '0; per = '0;
    model_reset();
    #1;
    check("reset_output", 64'(o_output), 64'd0);
    check("reset_frame", 64'(o_frame_pulse), 64'd0);
    check("reset_active", 64'(o_active), 64'd0);
    #20 rst_n = 1'b1;
    repeat (2) step();

    // Duty sweep over ten full periods each
    for (int d = 0; d < 4; d++) begin
      load(32'h0400_0000, 2'(d), 9'd100, 4'd0);
      hc = 0;
      repeat (640) begin
        step();
        if (o_output == 9'd100) hc++;
      end
      check($sformatf("duty%0d_high_count", d), 64'(hc), 64'(exp_hc[d]));
    end

    // Decay: volume 3, period 2, tick every 10 cycles; phase pinned at 0 so output = envelope
    load(32'd0, 2'd3, 9'd3, 4'd2);
    for (int k = 1; k <= 8; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (k == 6) check("active_before_fall", 64'(o_active), 64'd1);
      step();
      check($sformatf("decay_tick%0d", k), 64'(o_output), 64'(exp_env[k]));
      if (k >= 6) check($sformatf("active_tick%0d", k), 64'(o_active), 64'd0);
      repeat (8) step();
    end

    // Collision: the tick in the load cycle is discarded
    delta = 32'd0; duty = 2'd3; vol = 9'd5; per = 4'd1;
    note = 1'b1; tick = 1'b1;
    step();
    note = 1'b0; tick = 1'b0;
    step();
    check("collision_env", 64'(o_output), 64'd5);
    repeat (3) step();
    check("collision_hold", 64'(o_output), 64'd5);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("collision_next_tick", 64'(o_output), 64'd4);

    // Wrap with delta = -1, then enable gating
    load(32'hFFFF_FFFF, 2'd2, 9'd200, 4'd0);
    repeat (5) step();
    check("wrap_phase", 64'(dut.phase_q), 64'h0000_0000_FFFF_FFFB);
    en = 1'b0;
    repeat (10) begin
      step();
      check("disabled_output", 64'(o_output), 64'd0);
      check("disabled_frame", 64'(o_frame_pulse), 64'd0);
    end
    check("disabled_phase_hold", 64'(dut.phase_q), 64'h0000_0000_FFFF_FFFB);
    en = 1'b1;
    step();
    check("resume_phase", 64'(dut.phase_q), 64'h0000_0000_FFFF_FFFA);

    // Asynchronous reset mid-note
    load(32'd1, 2'd2, 9'd200, 4'd0);
    step();
    check("pre_reset_output", 64'(o_output), 64'd200);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_output", 64'(o_output), 64'd0);
    check("async_reset_frame", 64'(o_frame_pulse), 64'd0);
    check("async_reset_active", 64'(o_active), 64'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("post_reset_output", 64'(o_output), 64'd0);
    check("post_reset_active", 64'(o_active), 64'd0);

    // Retrigger mid-decay
    load(32'h0800_0000, 2'd0, 9'd20, 4'd2);
    repeat (3) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    load(32'h0200_0000, 2'd1, 9'd50, 4'd3);
    check("retrigger_phase", 64'(dut.phase_q), 64'd0);
    check("retrigger_cnt", 64'(dut.decay_cnt_q), 64'd0);
    step();
    check("retrigger_output", 64'(o_output), 64'd50);

    // Random traffic
    repeat (1500) begin
      note  = ($urandom_range(15) == 0);
      tick  = ($urandom_range(3) == 0);
      en    = ($urandom_range(9) != 0);
      delta = $urandom >> $urandom_range(8, 0);
      duty  = 2'($urandom_range(3));
      vol   = ($urandom_range(1) == 1) ? 9'($urandom_range(15)) : 9'($urandom_range(511));
      per   = 4'($urandom_range(3));
      step();
    end
    note = 1'b0; tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_channel.md
# pulse_channel

Parametrised pulse-wave voice, successor to the fixed 75%-duty pulse channel. It takes a note (phase delta, duty, volume, decay rate) on a strobe and runs its own phase accumulator and a tick-driven linear decay envelope. It produces a registered amplitude sample for the mixer. It sits between a note sequencer, which supplies `i_note_stb` and the note fields, and the output mixer/PWM stage.

## Interface
- `PHASE_WIDTH`, default 32: width of the phase accumulator and phase delta.
- `OUT_WIDTH`, default 9: width of the volume, envelope and output sample.
- `DECAY_WIDTH`, default 4: width of the decay period and decay tick counter.

Ports:
- `i_clk`  in  1: sole clock; all state updates on its rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_tick_stb`  in  1: one-cycle envelope tick, frame rate.
- `i_note_stb`  in  1: one-cycle strobe that loads the note fields below.
- `i_phase_delta`  in  `PHASE_WIDTH`: per-cycle phase increment (pitch).
- `i_duty`  in  2: duty select; 0 = 12.5%, 1 = 25%, 2 = 50%, 3 = 75%.
- `i_volume`  in  `OUT_WIDTH`: initial envelope value.
- `i_decay_period`  in  `DECAY_WIDTH`: ticks per envelope decrement; 0 = no decay.
- `i_enable`  in  1: channel run enable.
- `o_output`  out  `OUT_WIDTH`: registered sample.
- `o_frame_pulse`  out  1: registered phase MSB (square at note frequency).
- `o_active`  out  1: registered; envelope is non-zero.

## Operation
- State registers: `phase`, `delta`, `duty`, `period`, `envelope`, `decay_cnt`, plus the output registers.
- **Reset** (asynchronous, `i_rst_n` low) clears every register to 0. `o_output`, `o_frame_pulse` and `o_active` are all 0. Reset asserted mid-note kills the note immediately.
- **Note load**, on `i_note_stb` = 1:
  - `delta`, `duty` and `period` ← inputs.
  - `envelope` ← `i_volume`.
  - `phase` ← 0 and `decay_cnt` ← 0.
  - Applies regardless of `i_enable`.
- **Phase**, when `i_enable` = 1 and no note load: `phase` ← `phase + delta`, modulo 2^`PHASE_WIDTH` (silent wrap). When `i_enable` = 0, `phase` holds.
- **Duty compare**, with `p` = `phase[PHASE_WIDTH-1 -: 3]`:
  - duty 0: high when `p` == 0.
  - duty 1: high when `p[2:1]` == 0.
  - duty 2: high when `p[2]` == 0.
  - duty 3: high when `p[2:1]` != 3.
- **Envelope**, on `i_tick_stb` = 1 with no note load, `period` != 0 and `envelope` != 0:
  - If `decay_cnt` == `period`-1: `decay_cnt` ← 0 and `envelope` ← `envelope`-1.
  - Otherwise `decay_cnt` ← `decay_cnt`+1.
  - `envelope` saturates at 0; no further decrement and `decay_cnt` holds.
  - `period` = 0 leaves `envelope` constant.
  - Ticks count even when `i_enable` = 0.
- **Simultaneous `i_note_stb` and `i_tick_stb`:** the note load wins and the tick is discarded.
- **Outputs**, computed each cycle from the current registered state:
  - `o_output` ← (`i_enable` && high) ? `envelope` : 0.
  - `o_frame_pulse` ← `i_enable` ? `phase[MSB]` : 0.
  - `o_active` ← (`envelope` != 0).

## Timing
- Strobe sampled at edge N means the state is loaded at edge N; outputs reflect the loaded state at edge N+1. Latency from strobe to output is 1 cycle after the load edge.
- After a note load at edge N: `phase` = 0 after N, = `delta` after N+1, and so on. `o_output` after N+1 equals `i_volume`, because phase 0 is high for every duty.
- Changes to `i_duty`, `i_phase_delta`, `i_volume` and `i_decay_period` have no effect until the next `i_note_stb`.
- Envelope decrement caused by a tick at edge T is visible on `o_output` and `o_active` after edge T+1.
- No back-pressure. Strobes may arrive on consecutive cycles; each one reloads the note.

## Test plan
- **Reset:**
  - Assert `i_rst_n` = 0 asynchronously mid-note with `o_output` = 200. Required: all outputs go to 0 without a clock edge.
  - Release reset. Required: outputs stay 0 until a note load.
- **Duty:**
  - Default parameters, delta = 2^26 (64-cycle period), volume = 100, period = 0, enable = 1. Run 640 cycles per duty 0..3.
  - Required: high-sample counts of 80, 160, 320 and 480 respectively, with high value 100.
- **Decay:**
  - Volume = 3, decay period = 2, one tick every 10 cycles. Required: envelope steps 3→2 after tick 2, →1 after tick 4, →0 after tick 6.
  - Required: `o_active` falls 1 cycle after tick 6's edge, and later ticks leave the envelope at 0.
- **Collision:**
  - Assert `i_note_stb` and `i_tick_stb` in the same cycle with volume = 5 and period = 1.
  - Required: envelope = 5 and is not decremented; the next lone tick gives 4.
- **Wrap and enable:**
  - delta = 2^32-1. Required: phase decrements by 1 per cycle (modulo wrap).
  - Drop `i_enable` for 10 cycles. Required: phase holds, `o_output` = 0 and `o_frame_pulse` = 0. On re-enable, the phase resumes from the held value.
- **Retrigger:**
  - Issue a second `i_note_stb` mid-decay with volume = 50. Required: phase restarts at 0, envelope = 50, `decay_cnt` cleared, and `o_output` = 50 two edges after the strobe.
